// File: rtl/sram_pkg.sv
// sram_pkg: state encoding and response-buffer sizing shared by the SRAM
// pipeline controller and its testbench.
package sram_pkg;

    typedef enum logic [1:0] {ST_CLEAR, ST_DRAIN, ST_READY} state_e;

    // One buffer slot per pipeline stage plus one, so credits never stall streaming reads.
    function automatic int rsp_depth(input int read_latency);
        return read_latency + 1;
    endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo: small circular response FIFO; head is zero while empty.
module sram_rsp_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign valid_o = cnt_q != '0;
    assign data_o  = valid_o ? mem_q[rd_q] : '0;

    always_comb begin
        do_pop  = pop_i && valid_o;
        do_push = push_i && (cnt_q != CW'(DEPTH) || do_pop);
        wr_d    = do_push ? ((wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1) : wr_q;
        rd_d    = do_pop ? ((rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1) : rd_q;
        cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_data_i;
    end

endmodule

// File: rtl/sram_pipe_ctrl.sv
// sram_pipe_ctrl: byte-writable SRAM with pipelined reads, credit-limited
// request acceptance, in-order response FIFO and a zero-fill engine.
module sram_pipe_ctrl
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 4,
    parameter int READ_LATENCY   = 2,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we_n,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    input  logic                    clr_req,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    init_done
);
    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam int NB        = DATA_WIDTH / 8;
    localparam int RSP_DEPTH = rsp_depth(READ_LATENCY);
    localparam int OW        = $clog2(RSP_DEPTH + 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q;
    logic [OW-1:0]         out_q, out_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data, push_data;
    logic                  rd_acc, wr_acc, rsp_hs, push, clr_we;

    assign rd_acc  = req_valid && req_ready && req_we_n;
    assign wr_acc  = req_valid && req_ready && !req_we_n;
    assign rsp_hs  = rsp_valid && rsp_ready;
    assign rd_data = mem_q[req_addr];
    assign out_d   = out_q + OW'(rd_acc) - OW'(rsp_hs);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
        else     state_q <= state_d;
    end

    // Outstanding covers both the read pipeline and the FIFO, so zero means fully drained.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_CLEAR: state_d = (clr_addr_q == ADDR_WIDTH'(DEPTH - 1)) ? ST_READY : ST_CLEAR;
            ST_DRAIN: state_d = (out_q == '0) ? ST_CLEAR : ST_DRAIN;
            ST_READY: state_d = clr_req ? ST_DRAIN : ST_READY;
            default:  state_d = ST_READY;
        endcase
    end

    always_comb begin
        init_done = state_q == ST_READY;
        req_ready = init_done && !rst && (out_q < OW'(RSP_DEPTH));
        clr_we    = (state_q == ST_CLEAR) && !rst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_addr_q <= '0;
            out_q      <= '0;
        end else begin
            clr_addr_q <= clr_we ? clr_addr_q + 1'b1 : clr_addr_q;
            out_q      <= out_d;
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we) mem_q[clr_addr_q] <= '0;
        else if (wr_acc)
            for (int b = 0; b < NB; b++)
                if (req_be[b]) mem_q[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
    end

    // The array is read on the accept edge; remaining stages only delay the word.
    if (READ_LATENCY == 1) begin : g_lat1
        assign push      = rd_acc;
        assign push_data = rd_data;
    end else begin : g_pipe
        logic [READ_LATENCY-2:0] v_q;
        logic [DATA_WIDTH-1:0]   d_q [READ_LATENCY-1];
        always_ff @(posedge clk or posedge rst) begin
            if (rst) v_q <= '0;
            else     v_q <= {v_q, rd_acc};
        end
        always_ff @(posedge clk) begin
            d_q[0] <= rd_data;
            for (int i = 1; i < READ_LATENCY - 1; i++) d_q[i] <= d_q[i-1];
        end
        assign push      = v_q[READ_LATENCY-2];
        assign push_data = d_q[READ_LATENCY-2];
    end

    sram_rsp_fifo #(
        .WIDTH(DATA_WIDTH),
        .DEPTH(RSP_DEPTH)
    ) u_rsp_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_data_i(push_data),
        .pop_i      (rsp_ready),
        .valid_o    (rsp_valid),
        .data_o     (rsp_rdata)
    );

endmodule

// File: tb/tb_sram_pipe_ctrl.sv
// tb_sram_pipe_ctrl: scoreboard bench; read expectations come from a byte-level
// memory model at accept time and are compared when responses hand off.
module tb_sram_pipe_ctrl;
    logic        clk = 0, rst = 1;
    logic        req_valid = 0, req_we_n = 1, clr_req = 0, rsp_ready = 0;
    logic [3:0]  req_addr = 0, req_be = 0;
    logic [31:0] req_wdata = 0;
    logic        req_ready, rsp_valid, init_done;
    logic [31:0] rsp_rdata;

    logic [31:0] model [16];
    logic [31:0] exp_q [$];
    int          rsp_cyc [$];
    int          n_chk = 0, n_pass = 0, cyc = 0, acc_cnt = 0, acc_cyc = 0;

    sram_pipe_ctrl #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we_n(req_we_n), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_be(req_be), .clr_req(clr_req), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .init_done(init_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_model();
        for (int i = 0; i < 16; i++) model[i] = '0;
    endtask

    // Accepts are observed mid-cycle; the handshake completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst && req_valid && req_ready) begin
            if (req_we_n) exp_q.push_back(model[req_addr]);
            else for (int b = 0; b < 4; b++)
                if (req_be[b]) model[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
            acc_cnt++;
            acc_cyc = cyc;
        end
    end

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) chk("rsp_unexpected", rsp_rdata, 32'hxxxxxxxx);
            else chk("rsp_data", rsp_rdata, exp_q.pop_front());
            rsp_cyc.push_back(cyc);
        end
    end

    task automatic req(input logic we_n, input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        int n = acc_cnt;
        bit ok = 0;
        req_valid = 1; req_we_n = we_n; req_addr = a; req_wdata = d; req_be = be;
        for (int t = 0; t < 50 && !ok; t++) begin
            step();
            ok = acc_cnt != n;
        end
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic idle();
        req_valid = 0;
        req_we_n  = 1;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 100 && (exp_q.size() != 0 || rsp_valid); t++) step();
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
        chk({tag, "_init_done"}, init_done, 0);
    endtask

    initial begin
        #200000;
        chk("global_timeout", 0, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int c0, n0, n1;
        zero_model();
        repeat (3) step();
        chk_reset_outputs("rst");
        rst = 0;
        for (int i = 1; i <= 16; i++) begin
            step();
            chk("clr_req_ready", req_ready, i == 16);
        end
        chk("init_done", init_done, 1);
        rsp_ready = 1;
        for (int a = 0; a < 16; a++) req(1, 4'(a), 0, 0);
        idle();
        wait_drain();

        // Byte enables, write-then-read forwarding, read latency
        rsp_ready = 0;
        req(0, 3, 32'hAABBCCDD, 4'b1111);
        req(0, 3, 32'h11223344, 4'b0101);
        req(1, 3, 0, 0);
        idle();
        chk("be_lat_early", rsp_valid, 0);
        step();
        chk("be_lat_valid", rsp_valid, 1);
        chk("be_rdata", rsp_rdata, 32'hAA22CC44);
        rsp_ready = 1;
        wait_drain();

        // Streaming
        for (int a = 0; a < 16; a++) req(0, 4'(a), 32'h100 + 32'(a), 4'b1111);
        idle();
        step();
        rsp_cyc.delete();
        req(1, 0, 0, 0);
        c0 = acc_cyc;
        for (int a = 1; a < 16; a++) req(1, 4'(a), 0, 0);
        chk("stream_accept_span", acc_cyc - c0, 15);
        idle();
        wait_drain();
        chk("stream_rsp_count", rsp_cyc.size(), 16);
        if (rsp_cyc.size() == 16) chk("stream_rsp_span", rsp_cyc[15] - rsp_cyc[0], 15);

        // Backpressure
        rsp_ready = 0;
        n0 = acc_cnt;
        req_valid = 1; req_we_n = 1;
        for (int i = 0; i < 8; i++) begin
            req_addr = 4'(i);
            step();
        end
        chk("bp_accepts", acc_cnt - n0, 3);
        chk("bp_ready_low", req_ready, 0);
        chk("bp_head_hold", rsp_rdata, 32'h100);
        for (int p = 0; p < 3; p++) begin
            n1 = acc_cnt;
            rsp_ready = 1;
            step();
            rsp_ready = 0;
            step();
            step();
            chk("bp_pulse_accept", acc_cnt - n1, 1);
        end
        idle();
        rsp_ready = 1;
        wait_drain();

        // Clear with two reads in flight
        rsp_ready = 0;
        req(1, 2, 0, 0);
        req(1, 9, 0, 0);
        idle();
        step();
        step();
        clr_req = 1;
        step();
        clr_req = 0;
        zero_model();
        chk("drain_init_done", init_done, 0);
        chk("drain_req_ready", req_ready, 0);
        step();
        step();
        chk("drain_hold_valid", rsp_valid, 1);
        chk("drain_head", rsp_rdata, 32'h102);
        rsp_ready = 1;
        for (int i = 1; i <= 19; i++) begin
            step();
            chk("reclr_init_done", init_done, i == 19);
        end
        req(1, 2, 0, 0);
        req(1, 9, 0, 0);
        req(1, 15, 0, 0);
        idle();
        wait_drain();

        // Reset mid-operation flushes buffered reads
        req(0, 7, 32'hDEADBEEF, 4'b1111);
        req(0, 15, 32'hCAFEF00D, 4'b1111);
        rsp_ready = 0;
        req(1, 4, 0, 0);
        req(1, 7, 0, 0);
        idle();
        step();
        step();
        chk("pre_rst_valid", rsp_valid, 1);
        rst = 1;
        #1;
        chk_reset_outputs("rst_flush");
        exp_q.delete();
        zero_model();
        step();
        rst = 0;
        rsp_ready = 1;
        repeat (7) step();
        chk("clr_mid_init_done", init_done, 0);
        rst = 1;
        #1;
        chk_reset_outputs("rst_clr");
        step();
        rst = 0;
        for (int i = 1; i <= 16; i++) begin
            step();
            chk("restart_init_done", init_done, i == 16);
        end
        for (int a = 0; a < 16; a++) req(1, 4'(a), 0, 0);
        idle();
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
